// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: issues word-wide req/ack accesses for loads and stores.
// It aligns and extends load data, and holds the upstream pipeline while an access is in flight.
module lsu_mem_stage #(
  parameter int unsigned AW      = 6,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          we_i,
  input  logic [2:0]    funct3_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [4:0]    rd_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [31:0]   mem_rdata_i,
  output logic          resp_valid_o,
  output logic [31:0]   rdata_o,
  output logic [4:0]    rd_o,
  output logic          err_o,
  output logic          stall_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;

  logic            mem_we_d;
  logic [AW-1:0]   mem_addr_d;
  logic [3:0]      mem_be_d;
  logic [31:0]     mem_wdata_d;
  logic [31:0]     rdata_d;
  logic [4:0]      rd_out_d;
  logic            err_d;

  logic            illegal_c, misaligned_c;
  logic [3:0]      be_c;
  logic [31:0]     wdata_rep_c;
  logic [31:0]     load_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic            unused_addr;

  assign unused_addr = ^addr_i[31:AW+2];

  // Decode legality, byte enables and lane-replicated store data for the incoming request
  always_comb begin
    illegal_c    = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111) ||
                   (we_i && funct3_i[2]);
    misaligned_c = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    be_c         = 4'b1111;
    wdata_rep_c  = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_c        = 4'b0001 << addr_i[1:0];
        wdata_rep_c = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_c        = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Align and extend the returned read word using the captured size and offset
  always_comb begin
    byte_c = 8'(mem_rdata_i >> {off_q, 3'b000});
    half_c = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b100:  load_c = {24'h0, byte_c};
      3'b101:  load_c = {16'h0, half_c};
      default: load_c = mem_rdata_i;
    endcase
  end

  // Next-state, capture and response logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_be_d    = mem_be_o;
    mem_wdata_d = mem_wdata_o;
    rdata_d     = '0;
    rd_out_d    = '0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (illegal_c || misaligned_c) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d     = BUSY;
            f3_d        = funct3_i;
            off_d       = addr_i[1:0];
            rd_d        = rd_i;
            mem_we_d    = we_i;
            mem_addr_d  = addr_i[AW+1:2];
            mem_be_d    = be_c;
            mem_wdata_d = wdata_rep_c;
          end
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d  = RESP;
          rdata_d  = mem_we_o ? 32'h0 : load_c;
          rd_out_d = mem_we_o ? 5'd0 : rd_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      req_ready_o  <= 1'b1;
      stall_o      <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      rdata_o      <= '0;
      rd_o         <= '0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      req_ready_o  <= (state_d == IDLE);
      stall_o      <= (state_d != IDLE);
      mem_req_o    <= (state_d == BUSY);
      mem_we_o     <= mem_we_d;
      mem_addr_o   <= mem_addr_d;
      mem_be_o     <= mem_be_d;
      mem_wdata_o  <= mem_wdata_d;
      resp_valid_o <= (state_d == RESP);
      rdata_o      <= rdata_d;
      rd_o         <= rd_out_d;
      err_o        <= err_d;
    end
  end

endmodule
